// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown of in-flight writes at the ID/EX boundary.
// Ports: clk/reset (sync, active-high); issue_* describe the instruction in ID; flush
//   squashes all tracking; stall/issue_fire/fwd_a/fwd_b/busy_mask are combinational.
// Optional macro HAZ_FORWARD_EN: a source one cycle from retirement is forwarded
//   (fwd_a/fwd_b) instead of stalling; without it fwd_* are tied low.
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int NUM_REGS       = 8,
  parameter int MAX_LAT        = 4,
  parameter int LAT_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_wr,
  input  logic [LAT_WIDTH-1:0]      issue_lat,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rt,
  input  logic                      issue_use_rt,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue_fire,
  output logic                      fwd_a,
  output logic                      fwd_b,
  output logic [NUM_REGS-1:0]       busy_mask
);

  localparam logic [LAT_WIDTH-1:0] LAT_MAX = LAT_WIDTH'(MAX_LAT);
  localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(1);

  logic [LAT_WIDTH-1:0] cnt [NUM_REGS];
  logic [LAT_WIDTH-1:0] eff_lat;
  logic [LAT_WIDTH-1:0] cnt_a;
  logic [LAT_WIDTH-1:0] cnt_b;
  logic [LAT_WIDTH-1:0] cnt_d;
  logic                 pend_a;
  logic                 pend_b;
  logic                 raw_a;
  logic                 raw_b;
  logic                 waw;

  // Latency 0 behaves like 1; anything past MAX_LAT is clamped.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == '0)
      eff_lat = LAT_ONE;
    else if (issue_lat > LAT_MAX)
      eff_lat = LAT_MAX;
  end

  // Hazard checks use the pre-update counters, so rs == rd reads the old value.
  assign cnt_a  = cnt[issue_rs];
  assign cnt_b  = cnt[issue_rt];
  assign cnt_d  = cnt[issue_rd];
  assign pend_a = issue_valid && (issue_rs != '0) && (cnt_a != '0);
  assign pend_b = issue_valid && issue_use_rt && (issue_rt != '0) && (cnt_b != '0);

`ifdef HAZ_FORWARD_EN
  // cnt == 1 means the result sits in the MEM/WB latch and can be bypassed.
  assign raw_a = pend_a && (cnt_a > LAT_ONE);
  assign raw_b = pend_b && (cnt_b > LAT_ONE);
  assign fwd_a = issue_fire && pend_a && (cnt_a == LAT_ONE);
  assign fwd_b = issue_fire && pend_b && (cnt_b == LAT_ONE);
`else
  assign raw_a = pend_a;
  assign raw_b = pend_b;
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // A younger write must not retire before an older, longer one to the same register.
  assign waw        = issue_valid && issue_wr && (issue_rd != '0) && (cnt_d > eff_lat);
  assign stall      = raw_a || raw_b || waw;
  assign issue_fire = issue_valid && !stall;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_mask[i] = (cnt[i] != '0);
  end

  // r0 is hardwired: its counter never leaves zero.
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset || flush)
        cnt[i] <= '0;
      else if (issue_fire && issue_wr && (issue_rd == REG_ADDR_WIDTH'(i)))
        cnt[i] <= eff_lat;
      else if (cnt[i] != '0)
        cnt[i] <= cnt[i] - LAT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  typedef struct {
    logic       v;
    logic [2:0] rd;
    logic       wr;
    logic [2:0] lat;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urt;
    logic       fl;
    logic       e_stall;
    logic       e_fire;
    logic       e_fa;
    logic       e_fb;
    logic [7:0] e_busy;
  } vec_t;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [2:0] issue_rd;
  logic       issue_wr;
  logic [2:0] issue_lat;
  logic [2:0] issue_rs;
  logic [2:0] issue_rt;
  logic       issue_use_rt;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic       fwd_a;
  logic       fwd_b;
  logic [7:0] busy_mask;

  int total_cnt = 0;
  int pass_cnt  = 0;
  vec_t tbl[$];

  hazard_scoreboard #(
    .REG_ADDR_WIDTH(3),
    .NUM_REGS      (8),
    .MAX_LAT       (4),
    .LAT_WIDTH     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_wr    (issue_wr),
    .issue_lat   (issue_lat),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .issue_use_rt(issue_use_rt),
    .flush       (flush),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [2:0] rd, logic wr, logic [2:0] lat,
                              logic [2:0] rs, logic [2:0] rt, logic urt, logic fl,
                              logic e_stall, logic e_fire, logic e_fa, logic e_fb,
                              logic [7:0] e_busy);
    vec_t x;
    x.v = v; x.rd = rd; x.wr = wr; x.lat = lat; x.rs = rs; x.rt = rt;
    x.urt = urt; x.fl = fl; x.e_stall = e_stall; x.e_fire = e_fire;
    x.e_fa = e_fa; x.e_fb = e_fb; x.e_busy = e_busy;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    else
      pass_cnt++;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, then let the clock commit state.
  task automatic apply(input vec_t x, input int idx);
    issue_valid  = x.v;
    issue_rd     = x.rd;
    issue_wr     = x.wr;
    issue_lat    = x.lat;
    issue_rs     = x.rs;
    issue_rt     = x.rt;
    issue_use_rt = x.urt;
    flush        = x.fl;
    @(negedge clk);
    chk("stall", idx, {7'd0, stall}, {7'd0, x.e_stall});
    chk("issue_fire", idx, {7'd0, issue_fire}, {7'd0, x.e_fire});
    chk("fwd_a", idx, {7'd0, fwd_a}, {7'd0, x.e_fa});
    chk("fwd_b", idx, {7'd0, fwd_b}, {7'd0, x.e_fb});
    chk("busy_mask", idx, busy_mask, x.e_busy);
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t raw3;
  vec_t waw5;
  vec_t clamp7;

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    raw3   = mk(1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 8'h08);
    waw5   = mk(1, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h20);
    clamp7 = mk(1, 7, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 8'h80);

    // Producer r3, lat 3: counter runs 3,2,1 in the following cycles.
    tbl.push_back(mk(1, 3, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(raw3);
    tbl.push_back(raw3);
    tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, !FWD, FWD, FWD, 0, 8'h08));
    tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    // WAW: r5 lat 4 then r5 lat 1 waits until cnt[5] == 1, then r5 busy one more cycle.
    tbl.push_back(mk(1, 5, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(waw5);
    tbl.push_back(waw5);
    tbl.push_back(waw5);
    tbl.push_back(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h20));
    tbl.push_back(idle);
    // Flush with a dependent issue, then flush colliding with a write issue.
    tbl.push_back(mk(1, 2, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 0, 0, 8'h04));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 3, 1, 4, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00));
    tbl.push_back(idle);
    // r0 is never tracked; latency 0 write to r0 too.
    tbl.push_back(mk(1, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
    // rt only matters with issue_use_rt; r6 counter runs 4,3,2,1.
    tbl.push_back(mk(1, 6, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0, 8'h40));
    tbl.push_back(mk(1, 0, 0, 0, 1, 6, 1, 0, 1, 0, 0, 0, 8'h40));
    tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 8'h40));
    tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, !FWD, FWD, 0, FWD, 8'h40));
    tbl.push_back(idle);
    // Latency 7 clamps to 4: a lat-3 write to r7 waits exactly one cycle.
    tbl.push_back(mk(1, 7, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(clamp7);
    tbl.push_back(mk(1, 7, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 8'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80));
    tbl.push_back(idle);
    // Self-dependency reads the old value; the second one sees the first's write.
    tbl.push_back(mk(1, 4, 1, 2, 4, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 4, 1, 2, 4, 0, 0, 0, 1, 0, 0, 0, 8'h10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10));
    tbl.push_back(idle);

    // Reset with an instruction present.
    reset        = 1'b1;
    issue_valid  = 1'b1;
    issue_rd     = 3'd0;
    issue_wr     = 1'b0;
    issue_lat    = 3'd0;
    issue_rs     = 3'd0;
    issue_rt     = 3'd0;
    issue_use_rt = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", -1, {7'd0, stall}, 8'd0);
    chk("reset_fire", -1, {7'd0, issue_fire}, 8'd1);
    chk("reset_fwd", -1, {6'd0, fwd_a, fwd_b}, 8'd0);
    chk("reset_busy", -1, busy_mask, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back independent issue never stalls.
    for (int i = 0; i < 20; i++)
      apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00), 1000 + i);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // Reset mid-flight clears pending state.
    apply(mk(1, 1, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00), 2000);
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h02), 2001);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00), 2002);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
